// File: rtl/ring_led_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : ring_led_pwm
//  Purpose  : LED stage behind the GPIO ring counter. Each LED is driven by a
//             glitch-free PWM whose duty follows a per-LED level. The level
//             either ramps linearly toward its target (crossfade) or snaps to
//             it. A ring pattern that is not one-hot is also flagged.
//  Build    : define RING_LED_PWM_FADE_EN to enable the linear fade ramp and
//             its divider; leave it undefined for hard switching at the next
//             PWM period boundary (fading is then tied low).
//  Ports    : clk          - system clock
//             rst          - synchronous reset, active-high
//             ring_in      - ring counter pattern, expected one-hot
//             brightness   - on-level applied to active LEDs (live)
//             led          - registered PWM LED drive
//             fading       - registered, high while any level != target
//             pattern_err  - registered, high while ring_q is not one-hot
//  Revision : 1.0 - initial release
// ============================================================================
module ring_led_pwm #(
    parameter int N_LEDS   = 2,
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 196078
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_LEDS-1:0]   ring_in,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [N_LEDS-1:0]   led,
    output logic                fading,
    output logic                pattern_err
);

    // Last PWM count; the period is 2^PWM_BITS - 1 cycles, so a full-scale
    // level compares greater than every count and is always on.
    localparam logic [PWM_BITS-1:0] C_PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

    logic [N_LEDS-1:0]                ring_q;
    logic [N_LEDS-1:0][PWM_BITS-1:0]  target;
    logic [N_LEDS-1:0][PWM_BITS-1:0]  level_q;
    logic [N_LEDS-1:0][PWM_BITS-1:0]  level_d;
    logic [N_LEDS-1:0][PWM_BITS-1:0]  duty_sh_q;
    logic [PWM_BITS-1:0]              pwm_cnt_q;
    logic                             pwm_wrap;
    logic [N_LEDS-1:0]                led_q;
    logic [N_LEDS-1:0]                led_d;
    logic                             fading_q;
    logic                             fading_d;
    logic                             pattern_err_q;
    logic                             pattern_err_d;

    // Target follows brightness combinationally so a brightness change
    // retargets an ongoing ramp without restarting anything.
    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_target
        assign target[gi] = ring_q[gi] ? brightness : '0;
    end

`ifdef RING_LED_PWM_FADE_EN
    localparam int               DIV_W      = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(FADE_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             fade_tick;

    assign fade_tick = (div_q == C_DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else if (fade_tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // One LSB toward the current target per tick. Stepping only while the
    // level strictly differs keeps the arithmetic saturating and makes a
    // mid-ramp reversal turn around from the present level without overshoot.
    always_comb begin
        level_d = level_q;
        if (fade_tick) begin
            for (int i = 0; i < N_LEDS; i++) begin
                if (level_q[i] < target[i]) begin
                    level_d[i] = level_q[i] + PWM_BITS'(1);
                end else if (level_q[i] > target[i]) begin
                    level_d[i] = level_q[i] - PWM_BITS'(1);
                end
            end
        end
        fading_d = (level_q != target);
    end
`else
    always_comb begin
        level_d  = target;
        fading_d = 1'b0;
    end
`endif

    assign pwm_wrap = (pwm_cnt_q == C_PWM_LAST);

    always_comb begin
        led_d = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            led_d[i] = (pwm_cnt_q < duty_sh_q[i]);
        end
    end

    // Zero bits or more than one bit set both count as an error.
    assign pattern_err_d = !((ring_q != '0) &&
                             ((ring_q & (ring_q - N_LEDS'(1))) == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_q        <= '0;
            level_q       <= '0;
            duty_sh_q     <= '0;
            pwm_cnt_q     <= '0;
            led_q         <= '0;
            fading_q      <= 1'b0;
            pattern_err_q <= 1'b0;
        end else begin
            ring_q        <= ring_in;
            level_q       <= level_d;
            led_q         <= led_d;
            fading_q      <= fading_d;
            pattern_err_q <= pattern_err_d;
            if (pwm_wrap) begin
                pwm_cnt_q <= '0;
                // Duty is only swapped at the period boundary, so no runt
                // pulses. A coincident fade step is picked up one wrap later.
                duty_sh_q <= level_q;
            end else begin
                pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            end
        end
    end

    assign led         = led_q;
    assign fading      = fading_q;
    assign pattern_err = pattern_err_q;

endmodule
`default_nettype wire

// File: doc/ring_led_pwm.md
# ring_led_pwm

Downstream LED stage for the GPIO ring counter. It takes the one-hot ring pattern and an 8-bit brightness setting and drives the board LEDs with glitch-free PWM. When the ring advances, each LED ramps linearly between off and the set brightness, so the lit position crossfades instead of hard-switching. It also flags any ring pattern that is not one-hot.

## Interface
- `N_LEDS`, 2: ring width and LED count.
- `PWM_BITS`, 8: duty resolution. PWM period is 2^PWM_BITS − 1 cycles.
- `FADE_DIV`, 196078: clock cycles per fade step. At 50 MHz, a full 0→255 ramp takes about 1 s.

- `clk`  in  1: system clock.
- `rst`  in  1: synchronous reset, active-high.
- `ring_in`  in  N_LEDS: ring counter output, expected one-hot.
- `brightness`  in  PWM_BITS: on-level for the active LED.
- `led`  out  N_LEDS: PWM LED drive, registered.
- `fading`  out  1: high while any level differs from its target, registered.
- `pattern_err`  out  1: high while the registered `ring_in` is not one-hot (zero or multiple bits set), registered.

## Operation
- **Input register:** `ring_q <= ring_in` every cycle.
- **Target:** `target[i] = ring_q[i] ? brightness : 0`. This is combinational and tracks `brightness` live.
- **Level register:** `level[i]` is PWM_BITS wide. With fade enabled, on each fade tick it moves 1 LSB toward `target[i]` and holds when equal.
  - Arithmetic is saturating.
  - A level never overshoots its target, including when the target changes mid-ramp (reversal takes effect on the next tick).
- **Fade divider:** `div` counts 0..FADE_DIV−1 and wraps. `fade_tick` is high for one cycle when `div == FADE_DIV−1`.
- **PWM counter:** `pwm_cnt` counts 0..2^PWM_BITS−2 and wraps to 0.
- **Duty shadow:** `duty_sh[i] <= level[i]`, loaded only in the cycle `pwm_cnt` wraps to 0. Duty therefore changes only at period boundaries, so there are no runt pulses.
- **Output:** `led[i] <= (pwm_cnt < duty_sh[i])`.
  - Level 0 is always off.
  - Level 2^PWM_BITS−1 is always on.
  - Level k is high for k cycles of each period.
- **Status outputs:**
  - `fading <= |(level != target)`, evaluated across all LEDs.
  - `pattern_err <= (ring_q not one-hot)`.
  - A non-one-hot pattern is still displayed bitwise (all-zero fades everything out). It is not blocked.
- **Reset:** asserted in any cycle, mid-ramp or mid-period, it forces on the next edge:
  - `ring_q`, `level`, `duty_sh`, `div`, `pwm_cnt` = 0.
  - `led`, `fading`, `pattern_err` = 0.
- **After reset release:** the first fade tick comes FADE_DIV cycles later, and the first duty load happens at the first `pwm_cnt` wrap.

## Timing
- `ring_in` → `ring_q`: 1 cycle.
- `ring_q` → `pattern_err`: 1 cycle.
- `ring_q` → `level` step:
  - Fade enabled: next fade tick.
  - Fade disabled: next cycle.
- `level` → `duty_sh`: next `pwm_cnt` wrap, at most 2^PWM_BITS−1 cycles.
- `duty_sh` → `led`: 1 cycle.
- A full-scale ramp takes `brightness` × FADE_DIV cycles, within ±FADE_DIV.
- `fading` lags `level` by 1 cycle.
- A simultaneous fade tick and PWM wrap loads the pre-step level. The stepped value appears at the next wrap.
- Changing `brightness` mid-ramp retargets the ramp without a reset. Lowering it below the current level ramps down.

## Configuration
- **`RING_LED_PWM_FADE_EN` defined:**
  - Linear ramp as described above.
  - Fade divider present.
- **`RING_LED_PWM_FADE_EN` undefined:**
  - Divider removed.
  - `level[i] <= target[i]` every cycle, so hard switching occurs at the next PWM period boundary.
  - `fading` is tied to 0.
- All other behaviour and all ports are identical in both builds.

## Test plan
All scenarios use N_LEDS=2, PWM_BITS=4 (period 15), FADE_DIV=4, with fade enabled unless stated.

1. **Reset:** hold `rst` 3 cycles mid-operation → `led`=00, `fading`=0, `pattern_err`=0 on the next edge. After release, `led` stays 00 for at least one full period.
2. **Ramp up:** `brightness`=15, `ring_in`=01 → `level[0]` reaches 15 after 60±4 cycles and `fading` falls. `led[0]` is then constantly 1 and `led[1]` constantly 0.
3. **Crossfade:** from steady 01 at 15, step to 10 → `level[0]` falls 15→0 while `level[1]` rises 0→15 in lockstep, one step per 4 cycles. Measured high-time per period always equals the latched `duty_sh`.
4. **Duty accuracy:** set `brightness`=5 and wait until steady → `led[1]` high exactly 5 of every 15 cycles with no partial periods at transitions.
5. **Pattern error:** `ring_in`=11, then 00 → `pattern_err`=1 two cycles after each input change. With 11, both LEDs ramp to `brightness`; with 00, both fade to 0. Returning to 01 clears the flag after 2 cycles.
6. **Fade disabled build, mid-ramp reversal:**
   - With `RING_LED_PWM_FADE_EN` undefined: a 01→10 step causes `led` duty to swap fully within one period + 2 cycles, and `fading` stays 0.
   - With the macro defined: reversing mid-ramp at level 7 ramps back from 7 with no overshoot.
